// File: rtl/hazard_forward_unit.sv
// Decode-stage dependency checker: operand forwarding selects, load-use
// interlock and data-memory control pipe for the 8-bit MIPS pipeline.
module hazard_forward_unit #(
   parameter int DEPTH          = 3,
   parameter int SELW           = 2,
   parameter int ZERO_REG_EN    = 1,
   parameter int LOAD_INTERLOCK = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ins_valid,
   input  logic [23:0]     ins,
   output logic            stall,
   output logic [4:0]      op_dec,
   output logic [7:0]      imm,
   output logic            imm_sel,
   output logic [SELW-1:0] fwd_sel_a,
   output logic [SELW-1:0] fwd_sel_b,
   output logic [4:0]      rw_dm,
   output logic            mem_en_ex,
   output logic            mem_rw_ex,
   output logic            mem_mux_sel_dm
);

   localparam logic [4:0] OP_JMP = 5'b11000;
   localparam logic [4:0] OP_LD  = 5'b10100;
   localparam logic [4:0] OP_ST  = 5'b10101;

   typedef struct packed {
      logic [4:0] op;
      logic [4:0] ra;
      logic [4:0] rb;
      logic [4:0] rd;
      logic       dst_vld;
      logic       is_ld;
      logic       is_st;
      logic [7:0] imm;
      logic       imm_sel;
   } dec_t;

   typedef struct packed {
      logic [4:0] addr;
      logic       vld;
      logic       is_ld;
      logic       is_st;
   } dst_t;

   dec_t            dec_in;
   dec_t            dec_q, dec_d;
   dst_t [DEPTH:1]  dp_q, dp_d;
   logic            mem_en_q, mem_en_d;
   logic            mem_rw_q, mem_rw_d;
   logic            mem_mux_q, mem_mux_d;
   logic            stall_raw;
   logic            unused_bits;

   always_comb begin
      logic [4:0] op;
      logic       is_br;
      op     = ins[23:19];
      is_br  = (op == OP_JMP) || (op[4:2] == 3'b111);
      dec_in = '0;
      if (ins_valid) begin
         dec_in.op      = op;
         dec_in.rd      = ins[18:14];
         dec_in.ra      = is_br ? 5'd0 : ins[13:9];
         dec_in.rb      = is_br ? 5'd0 : ins[8:4];
         dec_in.is_ld   = (op == OP_LD);
         dec_in.is_st   = (op == OP_ST);
         dec_in.dst_vld = !(is_br || op == OP_ST);
         dec_in.imm     = ins[8:1];
         dec_in.imm_sel = (op[4:3] == 2'b01);
      end
   end

   // r0 is hardwired, so a load into it can never create a hazard
   always_comb begin
      logic hit;
      logic zero_ok;
      hit     = (ins[13:9] == dec_q.rd) || (ins[8:4] == dec_q.rd);
      zero_ok = !(ZERO_REG_EN != 0 && dec_q.rd == 5'd0);
      if (LOAD_INTERLOCK != 0)
         stall_raw = dec_q.is_ld && dec_q.dst_vld && ins_valid
                     && zero_ok && hit;
      else
         stall_raw = dec_q.is_ld;
      stall = reset && stall_raw;
   end

   always_comb begin
      dec_d     = stall ? '0 : dec_in;
      dp_d      = dp_q;
      dp_d[1]   = {dec_q.rd, dec_q.dst_vld, dec_q.is_ld, dec_q.is_st};
      for (int k = 2; k <= DEPTH; k++)
         dp_d[k] = dp_q[k-1];
      mem_en_d  = dec_q.is_ld | dec_q.is_st;
      mem_rw_d  = dec_q.is_st;
      mem_mux_d = dp_q[1].is_ld;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         dec_q     <= '0;
         dp_q      <= '0;
         mem_en_q  <= 1'b0;
         mem_rw_q  <= 1'b0;
         mem_mux_q <= 1'b0;
      end else begin
         dec_q     <= dec_d;
         dp_q      <= dp_d;
         mem_en_q  <= mem_en_d;
         mem_rw_q  <= mem_rw_d;
         mem_mux_q <= mem_mux_d;
      end
   end

   // scan oldest to youngest so the youngest producer overwrites
   always_comb begin
      fwd_sel_a = '0;
      fwd_sel_b = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (dp_q[k].vld && dp_q[k].addr == dec_q.ra)
            fwd_sel_a = SELW'(k);
         if (dp_q[k].vld && dp_q[k].addr == dec_q.rb)
            fwd_sel_b = SELW'(k);
      end
      if (ZERO_REG_EN != 0 && dec_q.ra == 5'd0)
         fwd_sel_a = '0;
      if (ZERO_REG_EN != 0 && dec_q.rb == 5'd0)
         fwd_sel_b = '0;
   end

   generate
      if (DEPTH >= 2) begin : g_rw
         assign rw_dm = dp_q[2].addr;
      end else begin : g_no_rw
         assign rw_dm = 5'd0;
      end
   endgenerate

   assign op_dec         = dec_q.op;
   assign imm            = dec_q.imm;
   assign imm_sel        = dec_q.imm_sel;
   assign mem_en_ex      = mem_en_q;
   assign mem_rw_ex      = mem_rw_q;
   assign mem_mux_sel_dm = mem_mux_q;

   assign unused_bits = ^{ins[0], dp_q[DEPTH].is_ld, dp_q[DEPTH].is_st};

endmodule
